// File: rtl/div_seq.sv
// div_seq: iterative radix-2 restoring divider for the DIV/DIVU/REM/REMU ops.
// It holds the EX stage with o_stall while DW iterations run, then shows the
// quotient or remainder for one cycle on o_rd_data, qualified by o_rd_en.
// A zero divisor and signed overflow skip the iteration and finish one cycle
// after they are accepted.
`timescale 1ns/1ps
module div_seq #(
   parameter int DW = 32
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [7:0]    i_instr_m,
   input  logic [DW-1:0] i_rs_1_data,
   input  logic [DW-1:0] i_rs_2_data,
   input  logic          i_flush,
   output logic          o_stall,
   output logic          o_busy,
   output logic          o_rd_en,
   output logic [DW-1:0] o_rd_data
);

   localparam int CW = $clog2(DW) + 1;

   // Bit positions inside the one-hot M-extension op vector
   localparam int IS_MUL    = 0;
   localparam int IS_MULH   = 1;
   localparam int IS_MULHSU = 2;
   localparam int IS_MULHU  = 3;
   localparam int IS_DIV    = 4;
   localparam int IS_DIVU   = 5;
   localparam int IS_REM    = 6;
   localparam int IS_REMU   = 7;

   localparam logic [DW-1:0] MIN_SIGNED = {1'b1, {(DW-1){1'b0}}};

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_e;

   state_e        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [DW-1:0] dividend_q, dividend_d;
   logic [DW-1:0] divisor_q, divisor_d;
   logic [DW:0]   remAcc_q, remAcc_d;
   logic          quotNeg_q, quotNeg_d;
   logic          remNeg_q, remNeg_d;
   logic          isRem_q, isRem_d;
   logic          busy_q, busy_d;
   logic [DW-1:0] rdData_q, rdData_d;

   logic          isDivOp;
   logic          isSignedOp;
   logic          isRemOp;
   logic          start;
   logic          rs1Neg;
   logic          rs2Neg;
   logic [DW-1:0] absRs1;
   logic [DW-1:0] absRs2;
   logic          divByZero;
   logic          overflow;
   logic [DW-1:0] specialRes;

   logic [DW+1:0] shiftedAcc;
   logic [DW+1:0] trial;
   logic [DW:0]   remStep;
   logic [DW-1:0] quotStep;
   logic [DW-1:0] quotFinal;
   logic [DW-1:0] remFinal;
   logic [DW-1:0] finalRes;

   // A vector that also carries a multiply bit is malformed and never starts
   // a divide. Reset is folded in so o_stall reads 0 while rst_n is low.
   assign isDivOp    = (|i_instr_m[IS_REMU:IS_DIV]) & ~(|i_instr_m[IS_MULHU:IS_MUL]);
   assign start      = rst_n & isDivOp & ~i_flush;
   assign isSignedOp = i_instr_m[IS_DIV] | i_instr_m[IS_REM];
   assign isRemOp    = i_instr_m[IS_REM] | i_instr_m[IS_REMU];

   // The iteration works on magnitudes; the signs are put back at the end
   assign rs1Neg = isSignedOp & i_rs_1_data[DW-1];
   assign rs2Neg = isSignedOp & i_rs_2_data[DW-1];
   assign absRs1 = rs1Neg ? -i_rs_1_data : i_rs_1_data;
   assign absRs2 = rs2Neg ? -i_rs_2_data : i_rs_2_data;

   assign divByZero = (i_rs_2_data == '0);
   assign overflow  = isSignedOp & (i_rs_1_data == MIN_SIGNED) & (i_rs_2_data == '1);

   // Fixed results for the two cases that bypass the iteration
   always_comb begin
      specialRes = '0;
      if (divByZero) begin
         specialRes = isRemOp ? i_rs_1_data : '1;
      end else if (overflow) begin
         specialRes = isRemOp ? '0 : MIN_SIGNED;
      end
   end

   // One restoring step: shift {rem, dividend} left, trial-subtract, keep or restore
   always_comb begin
      shiftedAcc = {remAcc_q, dividend_q[DW-1]};
      trial      = shiftedAcc - {2'b00, divisor_q};
      if (trial[DW+1]) begin
         remStep  = shiftedAcc[DW:0];
         quotStep = {dividend_q[DW-2:0], 1'b0};
      end else begin
         remStep  = trial[DW:0];
         quotStep = {dividend_q[DW-2:0], 1'b1};
      end
   end

   // Sign fix-up on the values the last step produces, ready to register into DONE
   always_comb begin
      quotFinal = quotNeg_q ? -quotStep : quotStep;
      remFinal  = remNeg_q ? -remStep[DW-1:0] : remStep[DW-1:0];
      finalRes  = isRem_q ? remFinal : quotFinal;
   end

   // Next-state, datapath updates and combinational handshake outputs
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      dividend_d = dividend_q;
      divisor_d  = divisor_q;
      remAcc_d   = remAcc_q;
      quotNeg_d  = quotNeg_q;
      remNeg_d   = remNeg_q;
      isRem_d    = isRem_q;
      rdData_d   = rdData_q;
      o_stall    = 1'b0;
      o_rd_en    = 1'b0;

      case (state_q)
         IDLE: begin
            if (start) begin
               o_stall = 1'b1;
               if (divByZero || overflow) begin
                  rdData_d = specialRes;
                  cnt_d    = '0;
                  state_d  = DONE;
               end else begin
                  dividend_d = absRs1;
                  divisor_d  = absRs2;
                  remAcc_d   = '0;
                  quotNeg_d  = rs1Neg ^ rs2Neg;
                  remNeg_d   = rs1Neg;
                  isRem_d    = isRemOp;
                  cnt_d      = CW'(DW);
                  state_d    = CALC;
               end
            end
         end

         CALC: begin
            if (i_flush) begin
               cnt_d   = '0;
               state_d = IDLE;
            end else begin
               o_stall    = 1'b1;
               remAcc_d   = remStep;
               dividend_d = quotStep;
               cnt_d      = cnt_q - CW'(1);
               if (cnt_q == CW'(1)) begin
                  rdData_d = finalRes;
                  state_d  = DONE;
               end
            end
         end

         DONE: begin
            o_rd_en = ~i_flush;
            state_d = IDLE;
         end

         default: begin
            cnt_d   = '0;
            state_d = IDLE;
         end
      endcase

      busy_d = (state_d != IDLE);
   end

   // State and datapath registers; reset clears everything immediately
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         dividend_q <= '0;
         divisor_q  <= '0;
         remAcc_q   <= '0;
         quotNeg_q  <= 1'b0;
         remNeg_q   <= 1'b0;
         isRem_q    <= 1'b0;
         busy_q     <= 1'b0;
         rdData_q   <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         dividend_q <= dividend_d;
         divisor_q  <= divisor_d;
         remAcc_q   <= remAcc_d;
         quotNeg_q  <= quotNeg_d;
         remNeg_q   <= remNeg_d;
         isRem_q    <= isRem_d;
         busy_q     <= busy_d;
         rdData_q   <= rdData_d;
      end
   end

   assign o_busy    = busy_q;
   assign o_rd_data = rdData_q;

endmodule
